// File: rtl/therm_gray_decoder.sv
`default_nettype none
// ============================================================================
// Module   : therm_gray_decoder
// Purpose  : Two-stage receive decoder for the 3-bit level link (thermometer
//            plus Gray), with per-beat error flags and error accounting.
// Revision : 1.0 - initial release
// ============================================================================
module therm_gray_decoder #(
   parameter int ERR_CNT_W = 8
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 in_valid,
   input  logic [6:0]           therm,
   input  logic [2:0]           gray,
   input  logic                 enable,
   input  logic                 clr_err,
   output logic                 out_valid,
   output logic [2:0]           value,
   output logic                 therm_err,
   output logic                 mismatch,
   output logic                 err_sticky,
   output logic [ERR_CNT_W-1:0] err_count
);

   localparam logic [ERR_CNT_W-1:0] c_cnt_max = '1;

   logic                 r_s1_valid;
   logic [6:0]           r_s1_therm;
   logic [2:0]           r_s1_gray;
   logic                 r_s1_enable;

   logic                 r_out_valid;
   logic [2:0]           r_value;
   logic                 r_therm_err;
   logic                 r_mismatch;
   logic                 r_err_sticky;
   logic [ERR_CNT_W-1:0] r_err_count;

   logic                 w_legal;
   logic [2:0]           w_therm_lvl;
   logic [2:0]           w_gray_lvl;
   logic [2:0]           w_value;
   logic                 w_mismatch;
   logic                 w_err_beat;

   // Stage 1: payload only moves on a valid beat; the valid bit always follows.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_s1_valid  <= 1'b0;
         r_s1_therm  <= '0;
         r_s1_gray   <= '0;
         r_s1_enable <= 1'b0;
      end else begin
         r_s1_valid <= in_valid;
         if (in_valid) begin
            r_s1_therm  <= therm;
            r_s1_gray   <= gray;
            r_s1_enable <= enable;
         end
      end
   end

   always_comb begin
      w_legal     = 1'b1;
      w_therm_lvl = 3'd0;
      case (r_s1_therm)
         7'b0000000: w_therm_lvl = 3'd0;
         7'b0000001: w_therm_lvl = 3'd1;
         7'b0000011: w_therm_lvl = 3'd2;
         7'b0000111: w_therm_lvl = 3'd3;
         7'b0001111: w_therm_lvl = 3'd4;
         7'b0011111: w_therm_lvl = 3'd5;
         7'b0111111: w_therm_lvl = 3'd6;
         7'b1111111: w_therm_lvl = 3'd7;
         default:    w_legal     = 1'b0;
      endcase
   end

   assign w_gray_lvl[2] = r_s1_gray[2];
   assign w_gray_lvl[1] = r_s1_gray[2] ^ r_s1_gray[1];
   assign w_gray_lvl[0] = w_gray_lvl[1] ^ r_s1_gray[0];

   // A legal thermometer wins; Gray is a fallback only while the link is enabled.
   always_comb begin
      w_value = 3'd0;
      if (w_legal)
         w_value = w_therm_lvl;
      else if (r_s1_enable)
         w_value = w_gray_lvl;
   end

   assign w_mismatch = r_s1_enable & w_legal & (w_therm_lvl != w_gray_lvl);
   assign w_err_beat = r_s1_valid & (~w_legal | w_mismatch);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_out_valid <= 1'b0;
         r_value     <= '0;
         r_therm_err <= 1'b0;
         r_mismatch  <= 1'b0;
      end else begin
         r_out_valid <= r_s1_valid;
         if (r_s1_valid) begin
            r_value     <= w_value;
            r_therm_err <= ~w_legal;
            r_mismatch  <= w_mismatch;
         end
      end
   end

   // Clear beats a coincident error beat, so that beat is dropped from the count.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_err_sticky <= 1'b0;
         r_err_count  <= '0;
      end else if (clr_err) begin
         r_err_sticky <= 1'b0;
         r_err_count  <= '0;
      end else if (w_err_beat) begin
         r_err_sticky <= 1'b1;
         if (r_err_count != c_cnt_max)
            r_err_count <= r_err_count + 1'b1;
      end
   end

   assign out_valid  = r_out_valid;
   assign value      = r_value;
   assign therm_err  = r_therm_err;
   assign mismatch   = r_mismatch;
   assign err_sticky = r_err_sticky;
   assign err_count  = r_err_count;

endmodule
`default_nettype wire

// File: tb/tb_therm_gray_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_therm_gray_decoder
// Purpose  : Directed self-checking bench for therm_gray_decoder (widths 8, 3).
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_therm_gray_decoder;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       in_valid;
   logic [6:0] therm;
   logic [2:0] gray;
   logic       enable;
   logic       clr_err;

   logic       out_valid, therm_err, mismatch, err_sticky;
   logic [2:0] value;
   logic [7:0] err_count;

   logic       out_valid3, therm_err3, mismatch3, err_sticky3;
   logic [2:0] value3;
   logic [2:0] err_count3;

   // {out_valid, value, therm_err, mismatch, err_sticky}
   logic [6:0] flags;
   assign flags = {out_valid, value, therm_err, mismatch, err_sticky};

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   therm_gray_decoder #(.ERR_CNT_W(8)) dut (
      .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .therm(therm),
      .gray(gray), .enable(enable), .clr_err(clr_err),
      .out_valid(out_valid), .value(value), .therm_err(therm_err),
      .mismatch(mismatch), .err_sticky(err_sticky), .err_count(err_count)
   );

   therm_gray_decoder #(.ERR_CNT_W(3)) dut3 (
      .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .therm(therm),
      .gray(gray), .enable(enable), .clr_err(clr_err),
      .out_valid(out_valid3), .value(value3), .therm_err(therm_err3),
      .mismatch(mismatch3), .err_sticky(err_sticky3), .err_count(err_count3)
   );

   // Inputs change on the falling edge; outputs are read there as well.
   task automatic apply_reset();
      @(negedge clk);
      reset_n  = 1'b0;
      in_valid = 1'b0;
      clr_err  = 1'b0;
      therm    = '0;
      gray     = '0;
      enable   = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
   endtask

   // Drives one beat and returns at the falling edge where it is on the outputs.
   task automatic send_beat(input logic [6:0] t, input logic [2:0] g, input logic e);
      therm    = t;
      gray     = g;
      enable   = e;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset();
      @(negedge clk);
      reset_n  = 1'b0;
      in_valid = 1'b0;
      clr_err  = 1'b0;
      therm    = '0;
      gray     = '0;
      enable   = 1'b0;
      #1;
      tests++;
      if (flags !== 7'd0) begin
         fails++;
         $display("FAIL reset_flags: got %b expected 0000000", flags);
      end
      tests++;
      if (err_count !== 8'd0) begin
         fails++;
         $display("FAIL reset_count: got %0d expected 0", err_count);
      end
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      tests++;
      if (out_valid !== 1'b0) begin
         fails++;
         $display("FAIL reset_release_valid: got %b expected 0", out_valid);
      end
   endtask

   task automatic test_single();
      apply_reset();
      therm    = 7'b0011111;
      gray     = 3'b111;
      enable   = 1'b1;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      tests++;
      if (out_valid !== 1'b0) begin
         fails++;
         $display("FAIL single_early_valid: got %b expected 0", out_valid);
      end
      @(negedge clk);
      tests++;
      if (flags !== {1'b1, 3'd5, 1'b0, 1'b0, 1'b0}) begin
         fails++;
         $display("FAIL single_flags: got %b expected %b", flags, {1'b1, 3'd5, 3'b000});
      end
      tests++;
      if (err_count !== 8'd0) begin
         fails++;
         $display("FAIL single_count: got %0d expected 0", err_count);
      end
      @(negedge clk);
      tests++;
      if (out_valid !== 1'b0) begin
         fails++;
         $display("FAIL single_strobe_width: got %b expected 0", out_valid);
      end
   endtask

   task automatic test_back_to_back();
      logic [2:0] gtab [8];
      gtab = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100};
      apply_reset();
      for (int c = 0; c < 11; c++) begin
         if (c >= 2 && c < 10) begin
            tests++;
            if (flags !== {1'b1, 3'(c - 2), 3'b000}) begin
               fails++;
               $display("FAIL sweep_level%0d: got %b expected %b", c - 2, flags, {1'b1, 3'(c - 2), 3'b000});
            end
         end else if (c == 10) begin
            tests++;
            if (out_valid !== 1'b0 || err_count !== 8'd0) begin
               fails++;
               $display("FAIL sweep_tail: got valid %b count %0d expected 0 0", out_valid, err_count);
            end
         end
         if (c < 8) begin
            therm    = 7'((8'd1 << c) - 8'd1);
            gray     = gtab[c];
            enable   = 1'b1;
            in_valid = 1'b1;
         end else begin
            in_valid = 1'b0;
         end
         @(negedge clk);
      end
   endtask

   task automatic test_therm_err();
      apply_reset();
      send_beat(7'b0010111, 3'b010, 1'b1);
      tests++;
      if (flags !== {1'b1, 3'd3, 1'b1, 1'b0, 1'b1} || err_count !== 8'd1) begin
         fails++;
         $display("FAIL therm_err_en1: got %b cnt %0d expected 1011101 cnt 1", flags, err_count);
      end
      send_beat(7'b0010111, 3'b010, 1'b0);
      tests++;
      if (flags !== {1'b1, 3'd0, 1'b1, 1'b0, 1'b1} || err_count !== 8'd2) begin
         fails++;
         $display("FAIL therm_err_en0: got %b cnt %0d expected 1000101 cnt 2", flags, err_count);
      end
   endtask

   task automatic test_mismatch();
      apply_reset();
      send_beat(7'b0000111, 3'b110, 1'b1);
      tests++;
      if (flags !== {1'b1, 3'd3, 1'b0, 1'b1, 1'b1} || err_count !== 8'd1) begin
         fails++;
         $display("FAIL mismatch_en1: got %b cnt %0d expected 1011011 cnt 1", flags, err_count);
      end
      send_beat(7'b0000111, 3'b000, 1'b0);
      tests++;
      if (flags !== {1'b1, 3'd3, 1'b0, 1'b0, 1'b1} || err_count !== 8'd1) begin
         fails++;
         $display("FAIL mismatch_en0: got %b cnt %0d expected 1011001 cnt 1", flags, err_count);
      end
   endtask

   task automatic test_saturate();
      apply_reset();
      for (int i = 0; i < 9; i++) begin
         therm    = 7'b1010101;
         gray     = 3'b000;
         enable   = 1'b0;
         in_valid = 1'b1;
         @(negedge clk);
      end
      in_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      tests++;
      if (err_count3 !== 3'd7 || err_sticky3 !== 1'b1) begin
         fails++;
         $display("FAIL sat_w3: got cnt %0d sticky %b expected cnt 7 sticky 1", err_count3, err_sticky3);
      end
      tests++;
      if (err_count !== 8'd9) begin
         fails++;
         $display("FAIL sat_w8: got cnt %0d expected 9", err_count);
      end
      therm    = 7'b1010101;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      clr_err  = 1'b1;
      @(negedge clk);
      clr_err = 1'b0;
      tests++;
      if (out_valid3 !== 1'b1 || therm_err3 !== 1'b1 || err_sticky3 !== 1'b0 || err_count3 !== 3'd0) begin
         fails++;
         $display("FAIL clr_priority_w3: got v%b te%b st%b cnt %0d expected v1 te1 st0 cnt 0",
                  out_valid3, therm_err3, err_sticky3, err_count3);
      end
      tests++;
      if (err_count !== 8'd0 || err_sticky !== 1'b0) begin
         fails++;
         $display("FAIL clr_priority_w8: got cnt %0d sticky %b expected 0 0", err_count, err_sticky);
      end
      send_beat(7'b1010101, 3'b000, 1'b0);
      tests++;
      if (err_count3 !== 3'd1 || err_sticky3 !== 1'b1) begin
         fails++;
         $display("FAIL post_clr_count: got cnt %0d sticky %b expected 1 1", err_count3, err_sticky3);
      end
   endtask

   task automatic test_reset_midflight();
      apply_reset();
      send_beat(7'b0010111, 3'b010, 1'b1);
      therm    = 7'b0011111;
      gray     = 3'b111;
      enable   = 1'b1;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      reset_n = 1'b0;
      #1;
      tests++;
      if (flags !== 7'd0 || err_count !== 8'd0 || err_count3 !== 3'd0) begin
         fails++;
         $display("FAIL midflight_in_reset: got %b cnt %0d/%0d expected 0000000 cnt 0/0",
                  flags, err_count, err_count3);
      end
      @(negedge clk);
      reset_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         tests++;
         if (out_valid !== 1'b0 || out_valid3 !== 1'b0) begin
            fails++;
            $display("FAIL midflight_ghost_c%0d: got valid %b/%b expected 0/0", i, out_valid, out_valid3);
         end
      end
   endtask

   initial begin
      reset_n  = 1'b1;
      in_valid = 1'b0;
      clr_err  = 1'b0;
      therm    = '0;
      gray     = '0;
      enable   = 1'b0;
      test_reset();
      test_single();
      test_back_to_back();
      test_therm_err();
      test_mismatch();
      test_saturate();
      test_reset_midflight();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
